// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared types and lane arithmetic for the weight-stationary array.
// SA_SAT_EN selects saturation instead of wrap when narrowing lanes to OW.
package sa_pkg;

  typedef enum logic [1:0] {IDLE, LOAD_W, COMPUTE, DRAIN} sa_state_e;

  localparam int SA_MAXW = 64;

  function automatic int sa_acc_w(input int dw, input int rows);
    return 2 * dw + $clog2(rows);
  endfunction

  // v holds an aw-bit accumulator; the result's low ow bits are the output lane.
  function automatic logic [SA_MAXW-1:0] sa_fit(input logic [SA_MAXW-1:0] v, input int aw,
                                                input int ow, input logic sgn);
    logic [SA_MAXW-1:0] amask;
    logic [SA_MAXW-1:0] omask;
    logic [SA_MAXW-1:0] x;
`ifdef SA_SAT_EN
    logic [SA_MAXW-1:0] hi;
    logic [SA_MAXW-1:0] lo;
`endif
    amask = (SA_MAXW'(1) << aw) - SA_MAXW'(1);
    omask = (SA_MAXW'(1) << ow) - SA_MAXW'(1);
    x = (sgn && v[aw-1]) ? (v | ~amask) : (v & amask);
`ifdef SA_SAT_EN
    hi = sgn ? (omask >> 1) : omask;
    lo = sgn ? ~(omask >> 1) : '0;
    if (sgn) begin
      if ($signed(x) > $signed(hi)) x = hi;
      else if ($signed(x) < $signed(lo)) x = lo;
    end else if (x > hi) begin
      x = hi;
    end
`else
    x = x & omask;
`endif
    return x;
  endfunction

endpackage

// File: rtl/sa_ws_pe.sv
// rtl/sa_ws_pe.sv - one MAC cell: stationary weight, activation passes right, psum passes down.
module sa_ws_pe #(
  parameter int DW = 8,
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          mode,
  input  logic          w_load,
  input  logic [DW-1:0] w_in,
  input  logic [DW-1:0] a_in,
  input  logic          a_vld_in,
  input  logic [AW-1:0] p_in,
  output logic [DW-1:0] a_out,
  output logic          a_vld_out,
  output logic [AW-1:0] p_out,
  output logic          p_vld_out
);
  logic [DW-1:0] w_q, w_d, a_q, a_d;
  logic          a_vld_q, a_vld_d, p_vld_q, p_vld_d;
  logic [AW-1:0] p_q, p_d;
  logic signed [2*DW-1:0] prod_s;
  logic [2*DW-1:0] prod_u;
  logic [AW-1:0]   prod_x;

  always_comb begin
    prod_s = $signed({{DW{a_in[DW-1]}}, a_in}) * $signed({{DW{w_q[DW-1]}}, w_q});
    prod_u = {{DW{1'b0}}, a_in} * {{DW{1'b0}}, w_q};
    prod_x = mode ? AW'(prod_s) : AW'(prod_u);
    w_d     = w_load ? w_in : w_q;
    a_d     = a_q;
    a_vld_d = a_vld_q;
    p_d     = p_q;
    p_vld_d = p_vld_q;
    if (en) begin
      a_d     = a_in;
      a_vld_d = a_vld_in;
      p_d     = p_in + prod_x;
      p_vld_d = a_vld_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_q     <= '0;
      a_q     <= '0;
      a_vld_q <= 1'b0;
      p_q     <= '0;
      p_vld_q <= 1'b0;
    end else begin
      w_q     <= w_d;
      a_q     <= a_d;
      a_vld_q <= a_vld_d;
      p_q     <= p_d;
      p_vld_q <= p_vld_d;
    end
  end

  assign a_out     = a_q;
  assign a_vld_out = a_vld_q;
  assign p_out     = p_q;
  assign p_vld_out = p_vld_q;
endmodule

// File: rtl/sa_ws_stream.sv
// rtl/sa_ws_stream.sv - ROWS x COLS weight-stationary MAC array with load/compute FSM and deskew.
// Lane narrowing to OW saturates when SA_SAT_EN is defined, otherwise wraps.
module sa_ws_stream
  import sa_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 8,
  parameter int AW   = sa_acc_w(DW, ROWS),
  parameter int OW   = AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_signed,
  input  logic               w_valid,
  output logic               w_ready,
  input  logic [COLS*DW-1:0] w_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ROWS*DW-1:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COLS*OW-1:0] out_data,
  output logic               out_last,
  output logic               busy
);
  localparam int TD = ROWS + COLS;
  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

  sa_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, wrow;
  logic mode_q, mode_d;
  logic [TD-1:0] tag_vld_q, tag_vld_d, tag_last_q, tag_last_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [COLS*OW-1:0] out_data_q, out_data_d;
  logic stall, accept, w_acc, pe_any, unused_ok;

  logic [DW-1:0] row_a [ROWS];
  logic          row_v [ROWS];
  logic [DW-1:0] ah    [ROWS][COLS+1];
  logic          avh   [ROWS][COLS+1];
  logic [AW-1:0] pv    [ROWS+1][COLS];
  logic          pvv   [ROWS][COLS];
  logic [AW-1:0] col_acc [COLS];
  logic [SA_MAXW-1:0] fit_w [COLS];

  assign stall  = out_valid_q && !out_ready;
  assign accept = in_valid && in_ready;
  assign w_acc  = w_valid && w_ready;
  assign wrow   = (state_q == IDLE) ? '0 : cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    if (w_acc) cnt_d = wrow + CW'(1);
    case (state_q)
      IDLE: if (w_acc) begin
        mode_d  = cfg_signed;
        state_d = (ROWS == 1) ? COMPUTE : LOAD_W;
      end
      LOAD_W:  if (w_acc && cnt_q == CW'(ROWS - 1)) state_d = COMPUTE;
      COMPUTE: if (accept && in_last) state_d = DRAIN;
      DRAIN:   if (tag_vld_q == '0 && (!out_valid_q || out_ready)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    w_ready  = (state_q == IDLE) || (state_q == LOAD_W);
    in_ready = (state_q == COMPUTE) && !stall;
  end

  // Row r enters the array r cycles late so its partial sum meets the one from above.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    if (r == 0) begin : g_direct
      assign row_a[r] = in_data[r*DW +: DW];
      assign row_v[r] = accept;
    end else begin : g_dly
      logic [DW-1:0] sk_q [r];
      logic [DW-1:0] sk_d [r];
      logic [r-1:0]  skv_q, skv_d;
      always_comb begin
        sk_d  = sk_q;
        skv_d = skv_q;
        if (!stall) begin
          sk_d[0]  = in_data[r*DW +: DW];
          skv_d[0] = accept;
          for (int i = 1; i < r; i++) begin
            sk_d[i]  = sk_q[i-1];
            skv_d[i] = skv_q[i-1];
          end
        end
      end
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sk_q  <= '{default: '0};
          skv_q <= '0;
        end else begin
          sk_q  <= sk_d;
          skv_q <= skv_d;
        end
      end
      assign row_a[r] = sk_q[r-1];
      assign row_v[r] = skv_q[r-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign ah[r][0]  = row_a[r];
    assign avh[r][0] = row_v[r];
    for (genvar c = 0; c < COLS; c++) begin : g_col
      if (r == 0) begin : g_top
        assign pv[0][c] = '0;
      end
      sa_ws_pe #(.DW(DW), .AW(AW)) u_pe (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (!stall),
        .mode      (mode_q),
        .w_load    (w_acc && (wrow == CW'(r))),
        .w_in      (w_data[c*DW +: DW]),
        .a_in      (ah[r][c]),
        .a_vld_in  (avh[r][c]),
        .p_in      (pv[r][c]),
        .a_out     (ah[r][c+1]),
        .a_vld_out (avh[r][c+1]),
        .p_out     (pv[r+1][c]),
        .p_vld_out (pvv[r][c])
      );
    end
  end

  // Column c leaves the array c cycles late; COLS-c stages realign all lanes.
  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    localparam int D = COLS - c;
    logic [AW-1:0] dk_q [D];
    logic [AW-1:0] dk_d [D];
    always_comb begin
      dk_d = dk_q;
      if (!stall) begin
        dk_d[0] = pv[ROWS][c];
        for (int i = 1; i < D; i++) dk_d[i] = dk_q[i-1];
      end
    end
    always_ff @(posedge clk) begin
      if (!rst_n) dk_q <= '{default: '0};
      else        dk_q <= dk_d;
    end
    assign col_acc[c] = dk_q[D-1];
  end

  always_comb begin
    tag_vld_d  = tag_vld_q;
    tag_last_d = tag_last_q;
    if (!stall) begin
      tag_vld_d  = {tag_vld_q[TD-2:0], accept};
      tag_last_d = {tag_last_q[TD-2:0], accept && in_last};
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    for (int c = 0; c < COLS; c++) fit_w[c] = sa_fit(SA_MAXW'(col_acc[c]), AW, OW, mode_q);
    if (!stall) begin
      out_valid_d = tag_vld_q[TD-1];
      out_last_d  = tag_vld_q[TD-1] && tag_last_q[TD-1];
      if (tag_vld_q[TD-1]) begin
        for (int c = 0; c < COLS; c++) out_data_d[c*OW +: OW] = fit_w[c][OW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_vld_q   <= '0;
      tag_last_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      tag_vld_q   <= tag_vld_d;
      tag_last_q  <= tag_last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    pe_any    = 1'b0;
    unused_ok = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      pe_any    = pe_any | row_v[r];
      unused_ok = unused_ok ^ (^ah[r][COLS]);
      for (int c = 0; c < COLS; c++) pe_any = pe_any | pvv[r][c] | avh[r][c+1];
    end
    for (int c = 0; c < COLS; c++) unused_ok = unused_ok ^ (^fit_w[c]);
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE) || (|tag_vld_q) || out_valid_q || pe_any;
endmodule
